wb_arbiter2: RTL and testbench

Two-master, one-slave Wishbone classic arbiter that shares a single slave (the firmware boot ROM or another on-chip memory) between the CPU instruction bus (master 0) and data bus (master 1). It grants the slave to one master per bus cycle with round-robin fairness and routes address, data, strobe and acknowledge. It holds the grant until the owning master drops `cyc`. An optional watchdog aborts stalled cycles with an error.

---
 rtl/wb_arbiter2_if.sv | 47 ++++
 rtl/wb_arbiter2.sv | 138 +++++++++++++
 tb/tb_wb_arbiter2.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter2_if.sv
// wb_arbiter2_if: bus bundle for the two-master / one-slave Wishbone arbiter.
//   m_*_i / m_*_o : both masters' request lines (packed, master n at [n*W +: W])
//                   and the broadcast read data / per-master ack and err.
//   s_*_o / s_*_i : the single shared slave port.
//   grant_o       : one-hot current owner, 00 when idle.
// Modports:
//   slave  - the arbiter's view (it is the slave the two masters talk to).
//   master - the surrounding system: masters driving requests, slave model
//            driving read data / ack / err.
interface wb_arbiter2_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [2*AW-1:0]     m_adr_i;
    logic [2*DW-1:0]     m_dat_i;
    logic [2*(DW/8)-1:0] m_sel_i;
    logic [1:0]          m_we_i;
    logic [1:0]          m_cyc_i;
    logic [1:0]          m_stb_i;
    logic [DW-1:0]       m_dat_o;
    logic [1:0]          m_ack_o;
    logic [1:0]          m_err_o;
    logic [AW-1:0]       s_adr_o;
    logic [DW-1:0]       s_dat_o;
    logic [DW/8-1:0]     s_sel_o;
    logic                s_we_o;
    logic                s_cyc_o;
    logic                s_stb_o;
    logic [DW-1:0]       s_dat_i;
    logic                s_ack_i;
    logic                s_err_i;
    logic [1:0]          grant_o;

    modport slave (
        input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
               s_dat_i, s_ack_i, s_err_i,
        output m_dat_o, m_ack_o, m_err_o,
               s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, grant_o
    );

    modport master (
        output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
               s_dat_i, s_ack_i, s_err_i,
        input  m_dat_o, m_ack_o, m_err_o,
               s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, grant_o
    );
endinterface

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: Wishbone classic arbiter sharing one slave (boot ROM / on-chip
// memory) between the CPU instruction bus (master 0) and data bus (master 1).
// Round-robin between simultaneous requests; the grant is held until the
// owner drops cyc, and a waiting master's cyc is honoured at that same edge.
//
// Ports:
//   wb_clk_i   - clock, rising edge
//   wb_reset_i - asynchronous, active-high reset
//   bus        - wb_arbiter2_if.slave (master requests, slave port, grant_o)
//
// Optional feature: define WB_ARB_TIMEOUT_EN to add a watchdog that aborts a
// strobe stalled for TIMEOUT cycles with a one-cycle m_err_o to the owner.
module wb_arbiter2 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_reset_i,
    wb_arbiter2_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t     state;
    logic       last;        // most recently granted master
    logic [1:0] grant;
    logic       raw_cyc;     // owner's cyc/stb before watchdog gating
    logic       raw_stb;
    logic       timeout_hit;

    // Grant is a decode of the state register, so it is glitch-free and
    // drops to 00 the moment reset asserts.
    assign grant = {state == OWN1, state == OWN0};

    // Arbitration FSM
    always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            state <= IDLE;
            last  <= 1'b1;       // master 0 wins the first contention
        end else begin
            unique case (state)
                IDLE: begin
                    // On contention grant whichever master did not go last.
                    if (bus.m_cyc_i[0] && (!bus.m_cyc_i[1] || last)) begin
                        state <= OWN0;
                        last  <= 1'b0;
                    end else if (bus.m_cyc_i[1]) begin
                        state <= OWN1;
                        last  <= 1'b1;
                    end
                end
                OWN0: begin
                    if (!bus.m_cyc_i[0]) begin
                        if (bus.m_cyc_i[1]) begin
                            state <= OWN1;
                            last  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                OWN1: begin
                    if (!bus.m_cyc_i[1]) begin
                        if (bus.m_cyc_i[0]) begin
                            state <= OWN0;
                            last  <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Slave-side mux: only the owner reaches the slave; everything is zero
    // while idle, so the non-owner's strobe can never leak through.
    always_comb begin
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_sel_o = '0;
        bus.s_we_o  = 1'b0;
        raw_cyc     = 1'b0;
        raw_stb     = 1'b0;
        unique case (state)
            OWN0: begin
                bus.s_adr_o = bus.m_adr_i[0 +: AW];
                bus.s_dat_o = bus.m_dat_i[0 +: DW];
                bus.s_sel_o = bus.m_sel_i[0 +: DW/8];
                bus.s_we_o  = bus.m_we_i[0];
                raw_cyc     = bus.m_cyc_i[0];
                raw_stb     = bus.m_stb_i[0];
            end
            OWN1: begin
                bus.s_adr_o = bus.m_adr_i[AW +: AW];
                bus.s_dat_o = bus.m_dat_i[DW +: DW];
                bus.s_sel_o = bus.m_sel_i[DW/8 +: DW/8];
                bus.s_we_o  = bus.m_we_i[1];
                raw_cyc     = bus.m_cyc_i[1];
                raw_stb     = bus.m_stb_i[1];
            end
            default: ;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    // Watchdog: counts stalled strobe cycles. In the cycle the count reaches
    // TIMEOUT the strobe is withdrawn from the slave, the owner gets err and
    // the count restarts, so a persistent strobe is aborted periodically.
    logic [CW-1:0] wd_cnt;

    assign timeout_hit = raw_stb && (wd_cnt == TO_VAL);

    always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
        if (wb_reset_i)
            wd_cnt <= '0;
        else if (!raw_stb || bus.s_ack_i || bus.s_err_i || timeout_hit)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
    wire unused_timeout = ^TO_VAL;
`endif

    assign bus.s_cyc_o = raw_cyc & ~timeout_hit;
    assign bus.s_stb_o = raw_stb & ~timeout_hit;
    assign bus.grant_o = grant;
    assign bus.m_dat_o = bus.s_dat_i;
    assign bus.m_ack_o = grant & {2{bus.s_ack_i & ~timeout_hit}};
    assign bus.m_err_o = grant & {2{bus.s_err_i | timeout_hit}};

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed self-checking bench for wb_arbiter2. A small ROM model registers
// its ack (one cycle after seeing stb) and returns 0xA000_0000 | address.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// there too, after settling.
module tb_wb_arbiter2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rom_on = 1'b1;
    int   errors = 0;
    int   checks = 0;

    wb_arbiter2_if #(.AW(AW), .DW(DW)) bus ();

    wb_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .wb_clk_i   (clk),
        .wb_reset_i (rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Registered-ack ROM model
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.s_ack_i <= 1'b0;
            bus.s_dat_i <= '0;
        end else begin
            bus.s_ack_i <= rom_on && bus.s_cyc_o && bus.s_stb_o && !bus.s_ack_i;
            if (bus.s_stb_o)
                bus.s_dat_i <= 32'hA000_0000 | bus.s_adr_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int n, input logic cyc, input logic stb, input logic [AW-1:0] adr);
        bus.m_cyc_i[n]          = cyc;
        bus.m_stb_i[n]          = stb;
        bus.m_adr_i[n*AW +: AW] = adr;
    endtask

    task automatic test_reset();
        bus.m_adr_i = {32'h0000_0066, 32'h0000_0055};
        bus.m_dat_i = {32'h1111_1111, 32'h2222_2222};
        bus.m_sel_i = 8'hC3;
        bus.m_we_i  = 2'b00;
        bus.m_cyc_i = 2'b00;
        bus.m_stb_i = 2'b00;
        bus.s_err_i = 1'b0;
        #1;
        checks++; if (bus.grant_o !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", bus.grant_o); end
        checks++; if ({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o} !== 3'b000) begin errors++; $display("FAIL reset_ctl got=%b exp=000", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o}); end
        checks++; if (bus.s_adr_o !== 32'h0 || bus.s_dat_o !== 32'h0 || bus.s_sel_o !== 4'h0) begin errors++; $display("FAIL reset_bus adr=%h dat=%h sel=%h exp=0", bus.s_adr_o, bus.s_dat_o, bus.s_sel_o); end
        checks++; if ({bus.m_ack_o, bus.m_err_o} !== 4'b0000) begin errors++; $display("FAIL reset_ackerr got=%b exp=0000", {bus.m_ack_o, bus.m_err_o}); end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_single_read();
        tick();
        drive(0, 1, 1, 32'h4);
        #1;
        checks++; if (bus.grant_o !== 2'b00) begin errors++; $display("FAIL sr_latency grant=%b exp=00", bus.grant_o); end
        tick();
        checks++; if (bus.grant_o !== 2'b01) begin errors++; $display("FAIL sr_grant got=%b exp=01", bus.grant_o); end
        checks++; if ({bus.s_cyc_o, bus.s_stb_o} !== 2'b11) begin errors++; $display("FAIL sr_stb got=%b exp=11", {bus.s_cyc_o, bus.s_stb_o}); end
        checks++; if (bus.s_adr_o !== 32'h4 || bus.s_sel_o !== 4'h3) begin errors++; $display("FAIL sr_mux adr=%h sel=%h exp=4/3", bus.s_adr_o, bus.s_sel_o); end
        checks++; if (bus.m_ack_o !== 2'b00) begin errors++; $display("FAIL sr_early_ack got=%b exp=00", bus.m_ack_o); end
        tick();
        checks++; if (bus.m_ack_o !== 2'b01) begin errors++; $display("FAIL sr_ack got=%b exp=01", bus.m_ack_o); end
        checks++; if (bus.m_dat_o !== 32'hA000_0004) begin errors++; $display("FAIL sr_data got=%h exp=a0000004", bus.m_dat_o); end
        drive(0, 0, 0, 32'h0);
        tick();
        checks++; if (bus.grant_o !== 2'b00 || bus.s_cyc_o !== 1'b0) begin errors++; $display("FAIL sr_release grant=%b cyc=%b exp=00/0", bus.grant_o, bus.s_cyc_o); end
    endtask

    task automatic test_contention();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        tick();
        drive(0, 1, 1, 32'h8);
        drive(1, 1, 1, 32'h10);
        tick();
        checks++; if (bus.grant_o !== 2'b01 || bus.s_adr_o !== 32'h8) begin errors++; $display("FAIL ct_first grant=%b adr=%h exp=01/8", bus.grant_o, bus.s_adr_o); end
        tick();
        checks++; if (bus.m_ack_o !== 2'b01) begin errors++; $display("FAIL ct_ack0 got=%b exp=01", bus.m_ack_o); end
        drive(0, 0, 0, 32'h0);
        tick();
        checks++; if (bus.grant_o !== 2'b10) begin errors++; $display("FAIL ct_handover grant=%b exp=10", bus.grant_o); end
        checks++; if (bus.s_adr_o !== 32'h10 || bus.s_sel_o !== 4'hC || bus.s_stb_o !== 1'b1) begin errors++; $display("FAIL ct_mux1 adr=%h sel=%h stb=%b exp=10/c/1", bus.s_adr_o, bus.s_sel_o, bus.s_stb_o); end
        tick();
        checks++; if (bus.m_ack_o !== 2'b10 || bus.m_dat_o !== 32'hA000_0010) begin errors++; $display("FAIL ct_ack1 ack=%b dat=%h exp=10/a0000010", bus.m_ack_o, bus.m_dat_o); end
        drive(1, 0, 0, 32'h0);
        tick();
        checks++; if (bus.grant_o !== 2'b00) begin errors++; $display("FAIL ct_idle grant=%b exp=00", bus.grant_o); end
        drive(0, 1, 1, 32'hC);
        drive(1, 1, 1, 32'h14);
        tick();
        checks++; if (bus.grant_o !== 2'b01) begin errors++; $display("FAIL ct_rr grant=%b exp=01", bus.grant_o); end
        drive(0, 0, 0, 32'h0);
        drive(1, 0, 0, 32'h0);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] adr;
        int acks;
        // master 0 went last, so master 1 wins this contention
        drive(0, 1, 1, 32'h30);
        drive(1, 1, 1, 32'h20);
        tick();
        checks++; if (bus.grant_o !== 2'b10) begin errors++; $display("FAIL bb_grant got=%b exp=10", bus.grant_o); end
        adr  = 32'h20;
        acks = 0;
        for (int c = 0; c < 40 && acks < 3; c++) begin
            checks++; if (bus.m_ack_o[0] !== 1'b0) begin errors++; $display("FAIL bb_nonowner_ack got=%b exp=0", bus.m_ack_o[0]); end
            if (bus.m_ack_o[1] === 1'b1) begin
                checks++; if (bus.grant_o !== 2'b10) begin errors++; $display("FAIL bb_hold grant=%b exp=10", bus.grant_o); end
                checks++; if (bus.m_dat_o !== (32'hA000_0000 | adr)) begin errors++; $display("FAIL bb_data got=%h exp=%h", bus.m_dat_o, 32'hA000_0000 | adr); end
                acks++;
                adr = adr + 32'h4;
                if (acks == 3) drive(1, 0, 0, 32'h0);
                else           drive(1, 1, 1, adr);
            end
            tick();
        end
        checks++; if (acks != 3) begin errors++; $display("FAIL bb_ack_count got=%0d exp=3", acks); end
        checks++; if (bus.grant_o !== 2'b01) begin errors++; $display("FAIL bb_handover grant=%b exp=01", bus.grant_o); end
        tick();
        checks++; if (bus.m_ack_o !== 2'b01 || bus.m_dat_o !== 32'hA000_0030) begin errors++; $display("FAIL bb_m0_ack ack=%b dat=%h exp=01/a0000030", bus.m_ack_o, bus.m_dat_o); end
        drive(0, 0, 0, 32'h0);
        tick();
    endtask

    task automatic test_reset_mid();
        drive(0, 1, 1, 32'h40);
        tick();
        checks++; if (bus.grant_o !== 2'b01) begin errors++; $display("FAIL rm_grant got=%b exp=01", bus.grant_o); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.grant_o !== 2'b00 || bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0) begin errors++; $display("FAIL rm_async grant=%b cyc=%b stb=%b exp=00/0/0", bus.grant_o, bus.s_cyc_o, bus.s_stb_o); end
        checks++; if (bus.s_adr_o !== 32'h0 || bus.m_ack_o !== 2'b00) begin errors++; $display("FAIL rm_async_bus adr=%h ack=%b exp=0/00", bus.s_adr_o, bus.m_ack_o); end
        @(negedge clk) rst = 1'b0;
        drive(1, 1, 1, 32'h44);
        tick();
        checks++; if (bus.grant_o !== 2'b01) begin errors++; $display("FAIL rm_after grant=%b exp=01", bus.grant_o); end
        drive(0, 0, 0, 32'h0);
        drive(1, 0, 0, 32'h0);
        tick();
        tick();
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        rom_on = 1'b0;
        drive(0, 1, 1, 32'h60);
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.s_stb_o !== 1'b1 || bus.m_err_o !== 2'b00) begin errors++; $display("FAIL to_stall%0d stb=%b err=%b exp=1/00", i, bus.s_stb_o, bus.m_err_o); end
            tick();
        end
        checks++; if (bus.m_err_o !== 2'b01 || bus.m_ack_o !== 2'b00) begin errors++; $display("FAIL to_err err=%b ack=%b exp=01/00", bus.m_err_o, bus.m_ack_o); end
        checks++; if ({bus.s_cyc_o, bus.s_stb_o} !== 2'b00 || bus.grant_o !== 2'b01) begin errors++; $display("FAIL to_abort cyc_stb=%b grant=%b exp=00/01", {bus.s_cyc_o, bus.s_stb_o}, bus.grant_o); end
        tick();
        checks++; if (bus.m_err_o !== 2'b00 || bus.s_stb_o !== 1'b1) begin errors++; $display("FAIL to_restart err=%b stb=%b exp=00/1", bus.m_err_o, bus.s_stb_o); end
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++; if (bus.m_err_o !== 2'b00) begin errors++; $display("FAIL to_recount%0d err=%b exp=00", i, bus.m_err_o); end
        end
        tick();
        checks++; if (bus.m_err_o !== 2'b01) begin errors++; $display("FAIL to_err2 err=%b exp=01", bus.m_err_o); end
        drive(0, 0, 0, 32'h0);
        rom_on = 1'b1;
        tick();
    endtask
`else
    task automatic test_error();
        drive(1, 1, 1, 32'h50);
        tick();
        checks++; if (bus.grant_o !== 2'b10) begin errors++; $display("FAIL er_grant got=%b exp=10", bus.grant_o); end
        bus.s_err_i = 1'b1;
        #1;
        checks++; if (bus.m_err_o !== 2'b10 || bus.m_ack_o !== 2'b00) begin errors++; $display("FAIL er_route err=%b ack=%b exp=10/00", bus.m_err_o, bus.m_ack_o); end
        bus.s_err_i = 1'b0;
        drive(1, 0, 0, 32'h0);
        tick();
        checks++; if (bus.m_err_o !== 2'b00 || bus.grant_o !== 2'b00) begin errors++; $display("FAIL er_clear err=%b grant=%b exp=00/00", bus.m_err_o, bus.grant_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_back_to_back();
        test_reset_mid();
`ifdef WB_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_error();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout sim time exceeded");
        $fatal(1, "time limit");
    end
endmodule
